serial_paralelo: RTL and testbench

Serial-to-parallel receiver for the PCIe-style physical layer. It recovers bytes from the single-bit stream produced by the transmit-side parallel-to-serial path. The block aligns to the COM symbol (0xBC), declares lock after a run of consecutive COMs, then delivers one byte per 8 serial clocks. COM bytes are flagged invalid, so the stream maps back to the transmitter's data/valid pair. It runs entirely in the `clk_32f` domain; byte-rate consumers sample on `byte_strobe`.

---
 rtl/serial_paralelo.sv | 104 ++++++++++
 tb/tb_serial_paralelo.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_paralelo.sv
// serial_paralelo: serial-to-parallel receiver.
// Finds the COM symbol at any bit offset, confirms byte alignment over a run
// of consecutive COMs, then emits one byte per 8 serial clocks with a strobe.
module serial_paralelo #(
  parameter logic [7:0]  COM        = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned CNT_W  = 4;

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BYTE_W - 1);
  localparam logic [CNT_W-1:0] LOCK_TGT = CNT_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    COUNT  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t            state;
  logic [BYTE_W-1:0] sr;
  logic [BIT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  com_cnt;

  logic [BYTE_W-1:0] nxt;
  logic              nxt_is_com;
  logic              at_boundary;

  // Byte completed by the bit arriving this cycle, and its classification
  assign nxt         = {sr[BYTE_W-2:0], data_in};
  assign nxt_is_com  = (nxt == COM);
  assign at_boundary = (bit_cnt == LAST_BIT);

  // Alignment FSM, shift register, counters and registered byte outputs
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state       <= SEARCH;
      sr          <= '0;
      bit_cnt     <= '0;
      com_cnt     <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
      active      <= 1'b0;
    end else begin
      sr          <= nxt;
      byte_strobe <= 1'b0;
      case (state)
        SEARCH: begin
          // Bit-exact match at any offset; the next boundary confirms alignment
          if (nxt_is_com) begin
            bit_cnt <= '0;
            com_cnt <= CNT_ONE;
            if (LOCK_TGT == CNT_ONE) begin
              state  <= ACTIVE;
              active <= 1'b1;
            end else begin
              state <= COUNT;
            end
          end
        end
        COUNT: begin
          bit_cnt <= bit_cnt + BIT_W'(1);
          if (at_boundary) begin
            if (nxt_is_com) begin
              com_cnt <= com_cnt + CNT_ONE;
              if ((com_cnt + CNT_ONE) == LOCK_TGT) begin
                state  <= ACTIVE;
                active <= 1'b1;
              end
            end else begin
              // Misaligned or broken run: restart the search from the next bit
              state   <= SEARCH;
              com_cnt <= '0;
            end
          end
        end
        ACTIVE: begin
          bit_cnt <= bit_cnt + BIT_W'(1);
          if (at_boundary) begin
            data_out    <= nxt;
            valid_out   <= !nxt_is_com;
            byte_strobe <= 1'b1;
          end
        end
        default: begin
          state <= SEARCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_paralelo.sv
// Bench for serial_paralelo: table-driven byte stream with a scoreboard queue
// of expected strobed bytes, plus hand sequences for lock and reset corners.
module tb_serial_paralelo;

  localparam logic [7:0] COM_SYM = 8'hBC;

  logic       clk_32f;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  serial_paralelo #(
    .COM        (COM_SYM),
    .LOCK_COUNT (4)
  ) dut (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .data_in     (data_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .byte_strobe (byte_strobe),
    .active      (active)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  typedef struct {
    logic [7:0] b;
    logic       exp_valid;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       valid;
  } exp_t;

  vec_t tbl [6];
  exp_t exp_q [$];

  int passed  = 0;
  int total   = 0;
  int strobes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed++;
  endtask

  // Scoreboard: every strobe must match the oldest expected byte
  always begin
    @(posedge clk_32f);
    #1;
    if (byte_strobe === 1'b1) begin
      exp_t e;
      strobes++;
      chk("strobe_while_active", 32'(active), 32'd1);
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_strobe: got data %0h valid %0b, expected no strobe",
                 data_out, valid_out);
      end else begin
        e = exp_q.pop_front();
        chk("data_out", 32'(data_out), 32'(e.data));
        chk("valid_out", 32'(valid_out), 32'(e.valid));
      end
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    data_in = b;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  // Last bit is presented; wait for the edge that samples it
  task automatic after_edge();
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_expect(input logic [7:0] b, input logic v);
    exp_t e;
    e.data  = b;
    e.valid = v;
    exp_q.push_back(e);
    send_byte(b);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_data_out"}, 32'(data_out), 32'h0);
    chk({tag, "_valid_out"}, 32'(valid_out), 32'd0);
    chk({tag, "_byte_strobe"}, 32'(byte_strobe), 32'd0);
    chk({tag, "_active"}, 32'(active), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk_32f);
    reset = 1'b0;
    #1;
    chk_cleared("reset");
    exp_q.delete();
    repeat (2) @(negedge clk_32f);
    reset = 1'b1;
  endtask

  task automatic drain_check(input string name);
    repeat (3) @(negedge clk_32f);
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Lock sequence: n COMs, checking active stays low until the last one
  task automatic send_coms_lock(input string name);
    for (int i = 0; i < 3; i++) send_byte(COM_SYM);
    after_edge();
    chk({name, "_not_yet"}, 32'(active), 32'd0);
    send_byte(COM_SYM);
    after_edge();
    chk({name, "_rise"}, 32'(active), 32'd1);
  endtask

  function automatic logic [7:0] tx_sym(input logic v, input logic [7:0] d);
    return v ? d : COM_SYM;
  endfunction

  initial begin
    tbl[0] = '{b: 8'hA5, exp_valid: 1'b1};
    tbl[1] = '{b: 8'h3C, exp_valid: 1'b1};
    tbl[2] = '{b: 8'h11, exp_valid: 1'b1};
    tbl[3] = '{b: 8'h55, exp_valid: 1'b1};
    tbl[4] = '{b: 8'hBC, exp_valid: 1'b0};
    tbl[5] = '{b: 8'h77, exp_valid: 1'b1};

    // Reset held with a toggling input: outputs stay cleared
    reset   = 1'b0;
    data_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_32f);
      data_in = ~data_in;
    end
    #1;
    chk_cleared("hold_reset");
    @(negedge clk_32f);
    reset   = 1'b1;
    data_in = 1'b0;
    repeat (64) @(negedge clk_32f);
    chk("idle_zeros_active", 32'(active), 32'd0);
    chk("idle_zeros_strobes", 32'(strobes), 32'd0);

    // Lock at an arbitrary offset: 3 junk bits then 4 COMs
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_coms_lock("offset_lock");
    for (int i = 0; i < 2; i++) send_expect(tbl[i].b, tbl[i].exp_valid);
    drain_check("offset_lock_drained");

    // Broken run: BC BC 00 must not lock; a fresh run of 4 does
    do_reset();
    send_byte(COM_SYM);
    send_byte(COM_SYM);
    send_byte(8'h00);
    after_edge();
    chk("broken_run_active", 32'(active), 32'd0);
    send_coms_lock("relock_after_break");
    // First strobe is 0x11, then idle/data mix
    for (int i = 2; i < 6; i++) send_expect(tbl[i].b, tbl[i].exp_valid);
    drain_check("idle_mix_drained");

    // Reset at bit 3 of a data byte clears outputs in the same cycle
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge clk_32f);
    reset = 1'b0;
    #1;
    chk_cleared("mid_byte_reset");
    repeat (2) @(negedge clk_32f);
    reset = 1'b1;
    send_byte(8'h22);
    send_coms_lock("post_reset_relock");
    send_expect(8'h5A, 1'b1);
    drain_check("post_reset_drained");

    // Loopback with a serializer model: 4 idle slots then 0x01..0x10
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(tx_sym(1'b0, 8'h00));
    after_edge();
    chk("loopback_active", 32'(active), 32'd1);
    for (int i = 1; i <= 16; i++) send_expect(tx_sym(1'b1, 8'(i)), 1'b1);
    drain_check("loopback_drained");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global time bound so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got no completion, expected finish before 200000");
    $fatal(1);
  end

endmodule
